// File: rtl/rgb_pwm_pkg.sv
// Shared types and sizes for the RGB fade sequencer and its channel slices.
package rgb_pwm_pkg;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned DUTY_W = 16;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [0:0] {
    IDLE,
    FADE
  } state_e;

endpackage

// File: rtl/rgb_fade_ctrl_if.sv
// Command-side and timer-side signals of the fade sequencer.
interface rgb_fade_ctrl_if
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned STEP_W = 8
);

  logic              start;
  logic              abort;
  duty_t             tgt_r;
  duty_t             tgt_g;
  duty_t             tgt_b;
  logic [STEP_W-1:0] step;
  duty_t             div;
  logic              period;
  logic              tim_en;
  duty_t             arr;
  duty_t             cmp_r;
  duty_t             cmp_g;
  duty_t             cmp_b;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, tgt_r, tgt_g, tgt_b, step, div, period,
    input  tim_en, arr, cmp_r, cmp_g, cmp_b, busy, done
  );

  modport slave (
    input  start, abort, tgt_r, tgt_g, tgt_b, step, div, period,
    output tim_en, arr, cmp_r, cmp_g, cmp_b, busy, done
  );

endinterface

// File: rtl/fade_chan.sv
// One LED channel: holds current and target duty and computes the clamped step toward target.
module fade_chan
  import rgb_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  duty_t tgt_new,
  input  logic  step_en,
  input  duty_t step,
  output duty_t cur,
  output logic  at_tgt,
  output logic  nxt_at_tgt
);

  duty_t cur_q;
  duty_t tgt_q;
  duty_t nxt;

  // Clamp to target whenever the remaining distance fits in one step, so no overshoot or wrap.
  always_comb begin
    nxt = cur_q;
    if (cur_q < tgt_q) begin
      nxt = ((tgt_q - cur_q) <= step) ? tgt_q : cur_q + step;
    end else if (cur_q > tgt_q) begin
      nxt = ((cur_q - tgt_q) <= step) ? tgt_q : cur_q - step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      tgt_q <= '0;
    end else begin
      if (load) begin
        tgt_q <= tgt_new;
      end
      if (step_en) begin
        cur_q <= nxt;
      end
    end
  end

  assign cur        = cur_q;
  assign at_tgt     = (cur_q == tgt_q);
  assign nxt_at_tgt = (nxt == tgt_q);

endmodule

// File: rtl/rgb_fade_ctrl.sv
// RGB duty fader: ramps three PWM compare values toward latched targets at period boundaries.
module rgb_fade_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter logic [15:0] ARR    = 16'hFFFF,
  parameter int unsigned STEP_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  rgb_fade_ctrl_if.slave bus
);

  state_e state_q;
  logic   period_q;
  duty_t  dcnt_q;
  duty_t  div_m1_q;
  duty_t  step_q;
  logic   done_q;
  logic   tim_en_q;

  duty_t              tgt_in [NUM_CH];
  duty_t              cur    [NUM_CH];
  logic [NUM_CH-1:0]  at_tgt;
  logic [NUM_CH-1:0]  nxt_at_tgt;

  logic  tick;
  logic  start_acc;
  logic  fade_tick;
  logic  step_en;
  duty_t div_m1;

  assign tick      = bus.period & ~period_q;
  assign start_acc = bus.start & ~bus.abort;
  // A start or abort in the same cycle takes precedence over a tick.
  assign fade_tick = (state_q == FADE) & tick & ~bus.start & ~bus.abort;
  assign step_en   = fade_tick & ~(&at_tgt) & (dcnt_q == '0);
  assign div_m1    = (bus.div == '0) ? '0 : bus.div - 16'd1;

  assign tgt_in[0] = bus.tgt_r;
  assign tgt_in[1] = bus.tgt_g;
  assign tgt_in[2] = bus.tgt_b;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    fade_chan u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (start_acc),
      .tgt_new    (tgt_in[i]),
      .step_en    (step_en),
      .step       (step_q),
      .cur        (cur[i]),
      .at_tgt     (at_tgt[i]),
      .nxt_at_tgt (nxt_at_tgt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= 1'b0;
      dcnt_q   <= '0;
      div_m1_q <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
      tim_en_q <= 1'b0;
    end else begin
      period_q <= bus.period;
      done_q   <= 1'b0;
      if (bus.abort) begin
        state_q <= IDLE;
      end else if (bus.start) begin
        state_q  <= FADE;
        tim_en_q <= 1'b1;
        step_q   <= duty_t'(bus.step);
        div_m1_q <= div_m1;
        dcnt_q   <= div_m1;
      end else if (fade_tick) begin
        if (&at_tgt) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end else if (dcnt_q == '0) begin
          dcnt_q <= div_m1_q;
          if (&nxt_at_tgt) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end else begin
          dcnt_q <= dcnt_q - 16'd1;
        end
      end
    end
  end

  assign bus.arr    = ARR;
  assign bus.cmp_r  = cur[0];
  assign bus.cmp_g  = cur[1];
  assign bus.cmp_b  = cur[2];
  assign bus.busy   = (state_q == FADE);
  assign bus.done   = done_q;
  assign bus.tim_en = tim_en_q;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Bench for rgb_fade_ctrl: per-cycle behavioural model compare plus directed literal checks.
module tb_rgb_fade_ctrl;

  logic clk;
  logic rst_n;
  logic chk_on;

  int n_vec;
  int n_fail;
  int done_cnt;

  rgb_fade_ctrl_if #(.STEP_W(8)) bus ();

  rgb_fade_ctrl #(
    .ARR    (16'hFFFF),
    .STEP_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: plain integers, tick counting up to the divide ratio.
  int m_cur [3];
  int m_tgt [3];
  int m_step;
  int m_div;
  int m_cnt;
  bit m_fade;
  bit m_done;
  bit m_ten;
  bit m_prev;

  function automatic bit on_target();
    return (m_cur[0] == m_tgt[0]) && (m_cur[1] == m_tgt[1]) && (m_cur[2] == m_tgt[2]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    bit tk;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        m_cur[c] = 0;
        m_tgt[c] = 0;
      end
      m_step = 0; m_div = 1; m_cnt = 0;
      m_fade = 0; m_done = 0; m_ten = 0; m_prev = 0;
    end else begin
      tk     = bus.period && !m_prev;
      m_prev = bus.period;
      m_done = 0;
      if (bus.abort) begin
        m_fade = 0;
      end else if (bus.start) begin
        m_tgt[0] = int'(bus.tgt_r);
        m_tgt[1] = int'(bus.tgt_g);
        m_tgt[2] = int'(bus.tgt_b);
        m_step   = int'(bus.step);
        m_div    = (bus.div == 0) ? 1 : int'(bus.div);
        m_cnt    = 0;
        m_fade   = 1;
        m_ten    = 1;
      end else if (m_fade && tk) begin
        if (!on_target()) begin
          m_cnt++;
          if (m_cnt >= m_div) begin
            m_cnt = 0;
            for (int c = 0; c < 3; c++) begin
              if (m_cur[c] < m_tgt[c]) m_cur[c] = (m_cur[c] + m_step > m_tgt[c]) ? m_tgt[c] : m_cur[c] + m_step;
              else if (m_cur[c] > m_tgt[c]) m_cur[c] = (m_cur[c] - m_step < m_tgt[c]) ? m_tgt[c] : m_cur[c] - m_step;
            end
          end
        end
        if (on_target()) begin
          m_fade = 0;
          m_done = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("cmp_r", int'(bus.cmp_r), m_cur[0]);
      chk("cmp_g", int'(bus.cmp_g), m_cur[1]);
      chk("cmp_b", int'(bus.cmp_b), m_cur[2]);
      chk("busy", int'(bus.busy), int'(m_fade));
      chk("done", int'(bus.done), int'(m_done));
      chk("tim_en", int'(bus.tim_en), int'(m_ten));
      chk("arr", int'(bus.arr), 65535);
      if (bus.done) done_cnt++;
    end
  end

  logic [15:0] s_r, s_g, s_b;
  logic        s_done, s_busy;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int r, input int g, input int b, input int st, input int dv,
                          input bit ab);
    bus.start = 1'b1;
    bus.abort = ab;
    bus.tgt_r = 16'(r);
    bus.tgt_g = 16'(g);
    bus.tgt_b = 16'(b);
    bus.step  = 8'(st);
    bus.div   = 16'(dv);
    wait_clk(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  // Raise period for hi clocks then drop it for lo clocks; sample just after the first edge.
  task automatic tick(input int hi, input int lo);
    bus.period = 1'b1;
    wait_clk(1);
    s_r = bus.cmp_r; s_g = bus.cmp_g; s_b = bus.cmp_b;
    s_done = bus.done; s_busy = bus.busy;
    if (hi > 1) wait_clk(hi - 1);
    bus.period = 1'b0;
    wait_clk(lo);
  endtask

  int d0;
  int exp_r1 [4] = '{30, 60, 90, 100};
  int exp_g2 [4] = '{745, 490, 235, 0};

  initial begin
    n_vec = 0; n_fail = 0; done_cnt = 0; chk_on = 0;
    rst_n = 1'b0;
    bus.start = 0; bus.abort = 0; bus.period = 0;
    bus.tgt_r = 0; bus.tgt_g = 0; bus.tgt_b = 0; bus.step = 0; bus.div = 0;
    wait_clk(3);
    rst_n  = 1'b1;
    chk_on = 1;
    chk("rst_cmp_r", int'(bus.cmp_r), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tim_en", int'(bus.tim_en), 0);
    chk("rst_arr", int'(bus.arr), 16'hFFFF);
    wait_clk(2);

    // Upward ramp on red, div=1, one tick per 4 clocks.
    do_start(100, 0, 0, 30, 1, 0);
    chk("t1_busy_rise", int'(bus.busy), 1);
    chk("t1_tim_en", int'(bus.tim_en), 1);
    for (int k = 0; k < 4; k++) begin
      tick(1, 3);
      chk("t1_cmp_r", int'(s_r), exp_r1[k]);
      chk("t1_done", int'(s_done), (k == 3) ? 1 : 0);
    end
    chk("t1_model_r", m_cur[0], 100);

    // Green up to 1000, then down to 0 with no wrap.
    do_start(100, 1000, 0, 255, 1, 0);
    for (int k = 0; k < 4; k++) tick(1, 3);
    chk("t2_pre_g", int'(s_g), 1000);
    do_start(100, 0, 0, 255, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1, 3);
      chk("t2_cmp_g", int'(s_g), exp_g2[k]);
      chk("t2_busy", int'(s_busy), (k == 3) ? 0 : 1);
      chk("t2_done", int'(s_done), (k == 3) ? 1 : 0);
    end

    // div=3, long period level: one step every third tick.
    do_start(10, 0, 0, 30, 3, 0);
    for (int k = 1; k <= 9; k++) begin
      tick(5, 3);
      chk("t3_cmp_r", int'(s_r), 100 - 30 * (k / 3));
      chk("t3_done", int'(s_done), (k == 9) ? 1 : 0);
    end

    // Retarget blue mid-ramp: 60 toward 200, then back down to 20.
    do_start(10, 0, 200, 60, 1, 0);
    tick(1, 3);
    chk("t4_b60", int'(s_b), 60);
    d0 = done_cnt;
    do_start(10, 0, 20, 25, 1, 0);
    tick(1, 3);
    chk("t4_b35", int'(s_b), 35);
    tick(1, 3);
    chk("t4_b20", int'(s_b), 20);
    chk("t4_done", int'(s_done), 1);
    tick(1, 3);
    tick(1, 3);
    chk("t4_done_count", done_cnt - d0, 1);

    // Abort at red=60, then simultaneous start+abort.
    do_start(200, 0, 20, 50, 1, 0);
    tick(1, 3);
    chk("t5_r60", int'(s_r), 60);
    bus.abort = 1'b1;
    wait_clk(1);
    bus.abort = 1'b0;
    chk("t5_busy_abort", int'(bus.busy), 0);
    d0 = done_cnt;
    for (int k = 0; k < 10; k++) tick(1, 3);
    chk("t5_r_hold", int'(bus.cmp_r), 60);
    chk("t5_no_done", done_cnt - d0, 0);
    do_start(500, 0, 20, 50, 1, 1);
    chk("t5_sa_busy", int'(bus.busy), 0);
    for (int k = 0; k < 3; k++) tick(1, 3);
    chk("t5_sa_r", int'(bus.cmp_r), 60);

    // Targets equal to current duties: exit on first tick with done.
    do_start(60, 0, 20, 5, 4, 0);
    chk("t6_busy", int'(bus.busy), 1);
    tick(1, 3);
    chk("t6_done", int'(s_done), 1);
    chk("t6_busy_fall", int'(s_busy), 0);

    // Asynchronous reset mid-ramp.
    do_start(1000, 0, 20, 100, 1, 0);
    tick(1, 3);
    tick(1, 3);
    chk("t7_r260", int'(s_r), 260);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_r", int'(bus.cmp_r), 0);
    chk("t7_rst_b", int'(bus.cmp_b), 0);
    chk("t7_rst_busy", int'(bus.busy), 0);
    chk("t7_rst_tim_en", int'(bus.tim_en), 0);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_fade_ctrl.md
# rgb_fade_ctrl

Sequencer that drives the compare inputs of the 16-bit PWM timer for the three LED channels (R, G, B). On a start request it latches per-channel target duty values and ramps each current duty toward its target in fixed steps, advancing only at PWM period boundaries, so that the timer reloads a consistent, glitch-free set of compares every period. It sits between the register and command logic and the PWM timer. It owns the timer's `arr` and `cmp0..cmp2` inputs and the timer enable.

## Interface
- `ARR`, 16'hFFFF, PWM period top value, driven constant on `arr`
- `STEP_W`, 8, width of the step-size input
- `clk` in 1: system clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: single-cycle request, latches targets and begins a ramp
- `abort` in 1: single-cycle request, freezes duties at current values and returns to idle
- `tgt_r`, `tgt_g`, `tgt_b` in 16: target duties, sampled only on accepted `start`
- `step` in STEP_W: per-step duty increment, sampled on `start`, zero-extended to 16
- `div` in 16: PWM periods per step, sampled on `start`; 0 is treated as 1
- `period` in 1: timer period-end level (`cnt == arr`), may stay high for several clocks
- `tim_en` out 1: timer enable
- `arr` out 16: equals `ARR`
- `cmp_r`, `cmp_g`, `cmp_b` out 16: current duties to timer `cmp0..cmp2`
- `busy` out 1: high in FADE
- `done` out 1: one-cycle pulse when a ramp reaches all targets

## Operation
- States: IDLE, FADE. IDLE→FADE on `start`. FADE→IDLE when all three duties equal their targets (pulse `done`), or on `abort` (no `done`).
- Tick: `tick = period & ~period_q`, a rising-edge detect on a registered copy of `period`. A level held for several clocks counts as one tick.
- Divider: `dcnt` loads `max(div,1)-1` on `start`. On each tick in FADE: if `dcnt==0`, perform a step and reload `dcnt`; otherwise decrement `dcnt`.
- Step per channel: if `cur<tgt`, then `cur = (tgt-cur <= step) ? tgt : cur+step`. If `cur>tgt`, apply the mirror rule. Otherwise hold. There is never overshoot and no 16-bit wrap.
- `step==0` with any channel off-target: the block stays in FADE indefinitely; `abort` is the only exit.
- `start` in FADE: retarget. New targets, step and div are latched, `dcnt` reloads, current duties are kept, and `done` is not emitted for the superseded ramp.
- `start` with targets equal to the current duties: enter FADE, then exit on the first tick with `done`.
- `start` and `abort` in the same cycle: `abort` wins.
- `tim_en` is 1 from the first `start` after reset onward. It is cleared only by reset.

## Timing
- Reset values: `cmp_r/g/b`=0, `busy`=0, `done`=0, `tim_en`=0, state IDLE, `dcnt`=0, `period_q`=0. `arr`=`ARR` always.
- `busy` rises in the cycle after `start`.
- Duty outputs change exactly 1 clock after the `period` rising edge that triggers a step. The timer's negedge sampling and period-end reload therefore see stable values.
- `done` is asserted in the same cycle the last step updates the duties. `busy` falls in that same cycle.
- `abort` takes effect on the next clock edge and outputs hold their values.
- Reset asserted mid-ramp forces all reset values immediately (asynchronous). The LED goes dark.

## Structure
- Package `rgb_pwm_pkg`: state enum {IDLE, FADE}, `NUM_CH`=3, `DUTY_W`=16.
- Sub-module `fade_chan`: one instance per channel. Holds `cur`/`tgt` and implements the clamped step and the `at_tgt` flag.
- The top level holds the FSM, edge detect, divider and output muxing.

## Test plan
- Reset then `start` with tgt_r=100, step=30, div=1, one tick per 4 clocks: cmp_r goes 30, 60, 90, 100 on successive ticks, and `done` pulses with the 100.
- Downward ramp: cur_g=1000, tgt_g=0, step=255: cmp_g goes 745, 490, 235, 0 with no wrap. `busy` falls with `done`.
- `div`=3 with `period` held high 5 clocks per tick: one step per 3 ticks, and the long level counts as a single tick.
- Retarget mid-ramp (cmp_b=60 heading to 200, new tgt_b=20, step=25): cmp_b goes 35, 20, and only one `done` is emitted.
- `abort` at cmp_r=60: state goes to IDLE and cmp_r stays 60 across 10 ticks with no `done`. Simultaneous `start`+`abort`: no ramp begins.
- Assert `rst_n` low mid-ramp: all outputs go to 0 without waiting for a clock.
